pingpong_multibank: RTL
=======================

Name: pingpong_multibank

Overview:
- Generalised successor of the two-half ping-pong buffer, with N banks of M words operated as a bank-level FIFO.
- The producer (e.g. JTAG shift side) fills the current write bank and commits it. The consumer (bus side) reads the oldest committed bank and releases it.
- Tracks per-bank word counts, free/full bank availability and sticky overflow/underflow errors. Sits between the JTAG interface and the system bus.

Parameters:
BITWIDTH, 32, data word width
NR_OF_ENTRIES, 512, words per bank (power of 2, >=2)
NR_OF_BANKS, 2, number of banks (power of 2, >=2)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
writeAddress  in  $clog2(NR_OF_ENTRIES)  word address within current write bank
writeData  in  BITWIDTH  write data
writeEnable  in  1  write writeData at writeAddress of write bank
commit  in  1  close current write bank, hand it to reader
writeBankFree  out  1  a bank is available for writing (fullCount < NR_OF_BANKS)
readAddress  in  $clog2(NR_OF_ENTRIES)  word address within current read bank
readData  out  BITWIDTH  registered read data
readBankValid  out  1  a committed bank is available (fullCount > 0)
readWordCount  out  $clog2(NR_OF_ENTRIES+1)  word count of current read bank
release  in  1  reader done with current read bank
fullCount  out  $clog2(NR_OF_BANKS+1)  number of committed, unreleased banks
overflowError  out  1  sticky: write/commit attempted with writeBankFree=0
underflowError  out  1  sticky: release attempted with readBankValid=0

Behaviour:
- State: writeIndex, readIndex (bank pointers, width $clog2(NR_OF_BANKS), wrap modulo NR_OF_BANKS), fullCount, wordCount[bank], open-bank length register.
- Reset values: writeIndex=0, readIndex=0, fullCount=0, length=0, readData=0, overflowError=0, underflowError=0. Hence writeBankFree=1, readBankValid=0 and readWordCount=0 after reset.
- Memory contents are not cleared by reset. Reset mid-operation discards all committed banks.
- Memory is a single array of NR_OF_BANKS*NR_OF_ENTRIES words, addressed as {bankIndex, wordAddress}.
- Write:
  - When writeEnable=1 and writeBankFree=1, the word is stored at {writeIndex, writeAddress} on the edge.
  - Length becomes max(length, writeAddress+1).
- Commit:
  - When commit=1 and writeBankFree=1: wordCount[writeIndex] is set to the length including any same-cycle write. writeIndex increments, length clears to 0, and fullCount increments.
  - Commit with no prior writes is legal and commits wordCount 0.
- Read:
  - readData is valid 1 cycle after readAddress and equals mem[{readIndex, readAddress}], with readIndex sampled in the same cycle as the address.
  - Reads occur regardless of readBankValid; data returned with readBankValid=0 is don't-care.
  - readWordCount is combinational: wordCount[readIndex].
- Release: when release=1 and readBankValid=1, readIndex increments and fullCount decrements.
- Simultaneous commit and release (both legal): both pointers advance and fullCount is unchanged.
- Full case:
  - With fullCount=NR_OF_BANKS, commit and release in the same cycle: release is accepted. Commit is rejected because writeBankFree is evaluated on the pre-edge value, and overflowError is set.
  - writeEnable or commit with writeBankFree=0: ignored (no memory or pointer change) and overflowError is set.
- Release with readBankValid=0: ignored and underflowError is set.
- Both error flags clear only on reset.
- Read and write to the same bank cannot collide except via the full-rejection path. Read-during-write to the same word returns old data.

Optional Feature:
- Macro: PINGPONG_WRITE_READBACK_EN.
- Defined: adds output writeReadData (BITWIDTH), registered, 1-cycle latency, equal to mem[{writeIndex, writeAddress}] sampled pre-edge. On same-cycle write it returns the old data. Its reset value is 0. Memory becomes true dual-read.
- Undefined: port absent and no second read path is inferred.

Test Plan:
- Reset, then write addresses 0..10 with 0xFFFFFFF0..0xFFFFFFFA and commit -> fullCount=1, readBankValid=1, readWordCount=11. Reading addresses 0..4 gives 0xFFFFFFF0..0xFFFFFFF4, each 1 cycle after its address.
- Fill and commit all NR_OF_BANKS=2 banks (lengths 3 and 5) -> writeBankFree=0. A further write of 0xDEAD is ignored and sets overflowError=1. Bank data and counts are unchanged.
- Release twice, then once more -> fullCount goes 1 then 0. The third release sets underflowError=1 and readIndex is unchanged.
- With fullCount=1: write address 7 and commit in the same cycle as release -> fullCount stays 1, the new bank's readWordCount=8, and pointers wrap to 0 correctly.
- Commit with no writes -> readWordCount=0 and readBankValid=1.
- Assert reset with fullCount=2 and both error flags set -> next cycle fullCount=0, flags=0, readData=0, writeBankFree=1. With PINGPONG_WRITE_READBACK_EN, writeReadData at address 2 returns the written 0x02 one cycle later.

Source files
------------

// File: rtl/pingpong_multibank.sv
// N-bank ping-pong buffer run as a bank-level FIFO between the JTAG producer and the bus consumer.
// Optional macro PINGPONG_WRITE_READBACK_EN adds a registered read port on the current write bank.
module pingpong_multibank #(
  parameter int BITWIDTH      = 32,
  parameter int NR_OF_ENTRIES = 512,
  parameter int NR_OF_BANKS   = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0]     writeAddress,
  input  logic [BITWIDTH-1:0]                  writeData,
  input  logic                                 writeEnable,
  input  logic                                 commit,
  output logic                                 writeBankFree,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0]     readAddress,
  output logic [BITWIDTH-1:0]                  readData,
  output logic                                 readBankValid,
  output logic [$clog2(NR_OF_ENTRIES+1)-1:0]   readWordCount,
  input  logic                                 releaseBank,
  output logic [$clog2(NR_OF_BANKS+1)-1:0]     fullCount,
  output logic                                 overflowError,
`ifdef PINGPONG_WRITE_READBACK_EN
  output logic                                 underflowError,
  output logic [BITWIDTH-1:0]                  writeReadData
`else
  output logic                                 underflowError
`endif
);

  localparam int AW = $clog2(NR_OF_ENTRIES);
  localparam int BW = $clog2(NR_OF_BANKS);
  localparam int CW = $clog2(NR_OF_ENTRIES + 1);
  localparam int FW = $clog2(NR_OF_BANKS + 1);
  localparam logic [FW-1:0] BANKS_FULL = FW'(NR_OF_BANKS);

  logic [BITWIDTH-1:0] mem [NR_OF_BANKS*NR_OF_ENTRIES];
  logic [CW-1:0]       word_count [NR_OF_BANKS];
  logic [BW-1:0]       write_index;
  logic [BW-1:0]       read_index;
  logic [CW-1:0]       length;
  logic [CW-1:0]       length_next;
  logic [CW-1:0]       addr_len;
  logic                wr_ok;
  logic                cm_ok;
  logic                rl_ok;

  // Acceptance is decided on pre-edge occupancy, so a commit into a full
  // buffer is refused even when a release lands on the same edge.
  always_comb begin
    writeBankFree = (fullCount < BANKS_FULL);
    readBankValid = (fullCount != '0);
    wr_ok         = writeEnable & writeBankFree;
    cm_ok         = commit & writeBankFree;
    rl_ok         = releaseBank & readBankValid;
    addr_len      = CW'(writeAddress) + CW'(1);
    length_next   = (wr_ok && (addr_len > length)) ? addr_len : length;
  end

  assign readWordCount = word_count[read_index];

  always_ff @(posedge clock) begin
    if (reset) begin
      write_index    <= '0;
      read_index     <= '0;
      fullCount      <= '0;
      length         <= '0;
      overflowError  <= 1'b0;
      underflowError <= 1'b0;
      for (int b = 0; b < NR_OF_BANKS; b++) word_count[b] <= '0;
    end else begin
      if (wr_ok) length <= length_next;
      if (cm_ok) begin
        word_count[write_index] <= length_next;
        write_index             <= write_index + BW'(1);
        length                  <= '0;
      end
      if (rl_ok) read_index <= read_index + BW'(1);
      if (cm_ok && !rl_ok)      fullCount <= fullCount + FW'(1);
      else if (rl_ok && !cm_ok) fullCount <= fullCount - FW'(1);
      if ((writeEnable || commit) && !writeBankFree) overflowError <= 1'b1;
      if (releaseBank && !readBankValid)             underflowError <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[{write_index, writeAddress}] <= writeData;
  end

  // Read stage: one-cycle registered output, old data on same-word collision.
  always_ff @(posedge clock) begin
    if (reset) readData <= '0;
    else       readData <= mem[{read_index, readAddress}];
  end

`ifdef PINGPONG_WRITE_READBACK_EN
  always_ff @(posedge clock) begin
    if (reset) writeReadData <= '0;
    else       writeReadData <= mem[{write_index, writeAddress}];
  end
`endif

endmodule
